ahb5_sram_slave: RTL and testbench

Synthesizable AHB5 subordinate backed by a flop-based word memory; it is the DUT that the AHB5 slave VIP drives and checks. Decodes the address phase, inserts a programmable number of wait states, performs byte/halfword/word reads and writes, and returns a two-cycle ERROR response for illegal transfers. It sits directly downstream of the VIP driver/dummy master on the AHB5 bus.

---
 rtl/ahb5_pkg.sv | 13 +
 rtl/ahb5_slave_mem.sv | 24 ++
 rtl/ahb5_sram_slave.sv | 96 +++++++++
 tb/tb_ahb5_sram_slave.sv | 133 +++++++++++++
 4 files changed

// File: rtl/ahb5_pkg.sv
// ahb5_pkg: shared AHB5 types, response codes, slave FSM states and byte-strobe helper
package ahb5_pkg;
  typedef enum logic [1:0] {TRANS_IDLE, TRANS_BUSY, TRANS_NONSEQ, TRANS_SEQ} htrans_e;
  typedef enum logic [2:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_DWORD} hsize_e;
  typedef enum logic [1:0] {IDLE_S, WAIT_S, ERR1_S, ERR2_S} slv_state_e;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  function automatic logic [7:0] byte_strb(input logic [2:0] off, input logic [2:0] size);
    logic [8:0] m;
    m = (9'd1 << (4'd1 << size)) - 9'd1;
    return m[7:0] << off;
  endfunction
endpackage

// File: rtl/ahb5_slave_mem.sv
// ahb5_slave_mem: DEPTH x DW flop array, byte-strobed write, combinational read, cleared on reset
// Ports: clk_i/rst_ni clock and async active-low reset; we_i/strb_i/wdata_i write port;
//        addr_i shared word address; rdata_o combinational read data.
module ahb5_slave_mem #(
  parameter int DW    = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [DW/8-1:0]          strb_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DW-1:0]            wdata_i,
  output logic [DW-1:0]            rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < DW/8; b++) if (strb_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/ahb5_sram_slave.sv
// ahb5_sram_slave: AHB5 subordinate over a flop word memory with programmable wait states and ERROR response
// Ports: HCLK/HRESETn clock and async active-low reset; HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT
//        address phase; HWDATA write data; HREADY bus ready in; HREADYOUT/HRESP/HRDATA data-phase response.
module ahb5_sram_slave
  import ahb5_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);
  localparam int NB = DATA_WIDTH/8;
  localparam int OB = $clog2(NB);
  localparam int AW = $clog2(MEM_DEPTH);
  slv_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [AW+OB-1:0]      addr_q;
  logic [2:0]            size_q;
  logic                  write_q, dphase_q, dphase_d;
  logic                  accept, err, ready, we;
  logic [NB-1:0]         strb;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  unused_ok;
  assign unused_ok = ^{HBURST, HPROT};
  assign ready  = !(state_q == WAIT_S || state_q == ERR1_S);
  assign accept = HSEL & HREADY & HTRANS[1] & ready;
  assign err    = ({1'b0, HADDR} >= 33'(MEM_DEPTH*NB))
                | (|(HADDR & ((32'd1 << HSIZE) - 32'd1)))
                | (HSIZE > 3'(OB));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_S: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = IDLE_S;
      end
      ERR1_S: state_d = ERR2_S;
      default: begin
        state_d = IDLE_S;
        if (accept) begin
          state_d = err ? ERR1_S : (WAIT_STATES > 0 ? WAIT_S : IDLE_S);
          cnt_d   = err ? 4'd0 : 4'(WAIT_STATES);
        end
      end
    endcase
  end
  // an OKAY data phase stays pending until it completes with HREADYOUT high
  assign dphase_d = ready ? (accept & ~err) : dphase_q;
  assign we       = dphase_q & write_q & ready;
  assign strb     = NB'(byte_strb(3'(addr_q[OB-1:0]), size_q));
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state_q  <= IDLE_S;
      cnt_q    <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      dphase_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dphase_q <= dphase_d;
      if (accept) begin
        addr_q  <= HADDR[AW+OB-1:0];
        size_q  <= HSIZE;
        write_q <= HWRITE;
      end
    end
  ahb5_slave_mem #(.DW(DATA_WIDTH), .DEPTH(MEM_DEPTH)) u_mem (
    .clk_i  (HCLK),
    .rst_ni (HRESETn),
    .we_i   (we),
    .strb_i (strb),
    .addr_i (addr_q[AW+OB-1:OB]),
    .wdata_i(HWDATA),
    .rdata_o(rdata)
  );
  assign HREADYOUT = ready;
  assign HRESP     = (state_q == ERR1_S || state_q == ERR2_S) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = (dphase_q & ~write_q & ready) ? rdata : '0;
endmodule

// File: tb/tb_ahb5_sram_slave.sv
// tb_ahb5_sram_slave: directed bench for ahb5_sram_slave with one and zero wait states
module tb_ahb5_sram_slave;
  import ahb5_pkg::*;
  logic        clk = 1'b0;
  logic        HRESETn, HSEL, HWRITE, sel;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        ro0, ro1, rs0, rs1, ready, resp;
  logic [31:0] rd0, rd1, rdata;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  ahb5_sram_slave #(.DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(1)) u_ws1 (
    .HCLK(clk), .HRESETn(HRESETn), .HSEL(HSEL & ~sel), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(ro0), .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0));
  ahb5_sram_slave #(.DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESETn(HRESETn), .HSEL(HSEL & sel), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(ro1), .HREADYOUT(ro1), .HRESP(rs1), .HRDATA(rd1));
  assign ready = sel ? ro1 : ro0;
  assign resp  = sel ? rs1 : rs0;
  assign rdata = sel ? rd1 : rd0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic addr_phase(input logic w, input logic [31:0] a, input logic [2:0] sz, input logic [1:0] tr);
    HSEL = 1'b1; HTRANS = tr; HADDR = a; HWRITE = w; HSIZE = sz;
  endtask
  task automatic go_idle();
    HSEL = 1'b0; HTRANS = TRANS_IDLE;
  endtask
  // single non-pipelined transfer: counts wait cycles, checks response and read data
  task automatic do_xfer(input string tag, input logic w, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, input int exp_wait, input logic exp_resp,
                         input logic [31:0] exp_rd);
    int n;
    @(posedge clk); #1 addr_phase(w, a, sz, TRANS_NONSEQ);
    @(posedge clk); #1 go_idle(); HWDATA = wd;
    n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      chk({tag, "_wresp"}, 32'(resp), 32'(exp_resp));
      n++;
      @(negedge clk);
    end
    chk({tag, "_waits"}, 32'(n), 32'(exp_wait));
    chk({tag, "_resp"}, 32'(resp), 32'(exp_resp));
    chk({tag, "_rdata"}, rdata, exp_rd);
  endtask
  // zero-wait INCR4 with a BUSY beat; per-cycle HWDATA and expected read data
  task automatic burst(input logic w);
    logic [1:0]  tr [6] = '{TRANS_NONSEQ, TRANS_SEQ, TRANS_BUSY, TRANS_SEQ, TRANS_SEQ, TRANS_IDLE};
    logic [31:0] ad [6] = '{32'h20, 32'h24, 32'h28, 32'h28, 32'h2C, 32'h2C};
    logic [31:0] hw [6] = '{32'h0, 32'hA0A0_0001, 32'hA1A1_0002, 32'hBAD0_BAD0, 32'hA2A2_0003, 32'hA3A3_0004};
    logic [31:0] re [6] = '{32'h0, 32'hA0A0_0001, 32'hA1A1_0002, 32'h0, 32'hA2A2_0003, 32'hA3A3_0004};
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      addr_phase(w, ad[k], SIZE_WORD, tr[k]);
      HBURST = 3'd3;
      HWDATA = hw[k];
      @(negedge clk);
      chk($sformatf("burst%0d_c%0d_ready", w, k), 32'(ready), 32'd1);
      chk($sformatf("burst%0d_c%0d_resp", w, k), 32'(resp), 32'd0);
      chk($sformatf("burst%0d_c%0d_rdata", w, k), rdata, w ? 32'h0 : re[k]);
    end
    @(posedge clk); #1 go_idle(); HBURST = 3'd0;
  endtask
  initial begin
    HRESETn = 1'b0; sel = 1'b0; HSEL = 1'b0; HTRANS = TRANS_IDLE; HADDR = '0; HWRITE = 1'b0;
    HSIZE = SIZE_WORD; HBURST = 3'd0; HPROT = 4'h3; HWDATA = '0;
    #3;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk); HRESETn = 1'b1;
    do_xfer("w_dead", 1'b1, 32'h10, SIZE_WORD, 32'hDEADBEEF, 1, 1'b0, 32'h0);
    do_xfer("r_dead", 1'b0, 32'h10, SIZE_WORD, 32'h0, 1, 1'b0, 32'hDEADBEEF);
    do_xfer("w_word", 1'b1, 32'h10, SIZE_WORD, 32'h11223344, 1, 1'b0, 32'h0);
    do_xfer("w_byte", 1'b1, 32'h13, SIZE_BYTE, 32'hAA00_0000, 1, 1'b0, 32'h0);
    do_xfer("r_byte", 1'b0, 32'h10, SIZE_WORD, 32'h0, 1, 1'b0, 32'hAA223344);
    do_xfer("w_half", 1'b1, 32'h12, SIZE_HALF, 32'h5566_FFFF, 1, 1'b0, 32'h0);
    do_xfer("r_half", 1'b0, 32'h10, SIZE_WORD, 32'h0, 1, 1'b0, 32'h55663344);
    do_xfer("r_mis", 1'b0, 32'h02, SIZE_WORD, 32'h0, 1, 1'b1, 32'h0);
    do_xfer("w_mis", 1'b1, 32'h12, SIZE_WORD, 32'hFFFFFFFF, 1, 1'b1, 32'h0);
    do_xfer("w_big", 1'b1, 32'h10, SIZE_DWORD, 32'hFFFFFFFF, 1, 1'b1, 32'h0);
    do_xfer("r_keep", 1'b0, 32'h10, SIZE_WORD, 32'h0, 1, 1'b0, 32'h55663344);
    do_xfer("r_last", 1'b0, 32'h3FC, SIZE_WORD, 32'h0, 1, 1'b0, 32'h0);
    // out-of-range write, then a NONSEQ read accepted during the second error cycle
    @(posedge clk); #1 addr_phase(1'b1, 32'h400, SIZE_WORD, TRANS_NONSEQ);
    @(posedge clk); #1 go_idle(); HWDATA = 32'hFFFFFFFF;
    @(negedge clk);
    chk("err1_ready", 32'(ready), 32'd0);
    chk("err1_resp", 32'(resp), 32'd1);
    @(posedge clk); #1 addr_phase(1'b0, 32'h10, SIZE_WORD, TRANS_NONSEQ);
    @(negedge clk);
    chk("err2_ready", 32'(ready), 32'd1);
    chk("err2_resp", 32'(resp), 32'd1);
    @(posedge clk); #1 go_idle();
    @(negedge clk);
    chk("post_err_wait_ready", 32'(ready), 32'd0);
    chk("post_err_wait_resp", 32'(resp), 32'd0);
    @(negedge clk);
    chk("post_err_ready", 32'(ready), 32'd1);
    chk("post_err_resp", 32'(resp), 32'd0);
    chk("post_err_rdata", rdata, 32'h55663344);
    sel = 1'b1;
    burst(1'b1);
    burst(1'b0);
    do_xfer("ws0_r28", 1'b0, 32'h28, SIZE_WORD, 32'h0, 0, 1'b0, 32'hA2A2_0003);
    sel = 1'b0;
    // reset asserted while the write sits in its wait state
    @(posedge clk); #1 addr_phase(1'b1, 32'h40, SIZE_WORD, TRANS_NONSEQ);
    @(posedge clk); #1 go_idle(); HWDATA = 32'h12345678;
    @(negedge clk);
    chk("midrst_pre_ready", 32'(ready), 32'd0);
    HRESETn = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_resp", 32'(resp), 32'd0);
    chk("midrst_rdata", rdata, 32'h0);
    @(negedge clk); HRESETn = 1'b1;
    do_xfer("r_after_rst40", 1'b0, 32'h40, SIZE_WORD, 32'h0, 1, 1'b0, 32'h0);
    do_xfer("r_after_rst10", 1'b0, 32'h10, SIZE_WORD, 32'h0, 1, 1'b0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
